// File: rtl/cp0_pkg.sv
// Purpose: shared constants for the coprocessor-0 slice (register numbers, exception codes, bit positions, vectors).
// Latency: none; this file holds only declarations and one pure function.
// Backpressure: not applicable.
package cp0_pkg;

  // CP0 register numbers as seen by mtc0/mfc0
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;
  localparam logic [4:0] CP0_CONFIG   = 5'd16;

  // ExcCode values recorded in Cause
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  // Status bit positions
  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_BEV   = 22;

  // Cause bit positions
  localparam int CA_BD     = 31;
  localparam int CA_TI     = 30;
  localparam int CA_IP_LO  = 8;
  localparam int CA_EXC_LO = 2;

  // Software-writable fields and reset image
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] STATUS_RST   = 32'h0040_0000;

  // Exception entry vectors
  localparam logic [31:0] VEC_BEV  = 32'hBFC0_0380;
  localparam logic [31:0] VEC_NORM = 32'h8000_0180;

  // Redirect target: ERET returns to EPC, otherwise the BEV-selected vector
  function automatic logic [31:0] exc_vector(input logic is_eret, input logic bev,
                                             input logic [31:0] epc);
    if (is_eret)  return epc;
    else if (bev) return VEC_BEV;
    else          return VEC_NORM;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Purpose: Count/Compare timer with power-of-two prescaler and the timer-interrupt flag TI.
// Latency: writes and ticks land at the next clock edge; TI sets on the edge a tick makes Count equal Compare.
// Backpressure: none; write strobes are always accepted.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  localparam int            PW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic          ti_q, ti_d;
  logic          tick;

  // Next-state: tick advances Count; Count write restarts the prescaler; Compare write always clears TI
  always_comb begin
    tick      = (presc_q == PRESC_MAX);
    presc_d   = tick ? '0 : presc_q + 1'b1;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (tick) begin
      count_d = count_q + 32'd1;
      if (count_q + 32'd1 == compare_q) ti_d = 1'b1;
    end
    // A software load of Count never raises TI, even if it lands on Compare
    if (count_we) begin
      count_d = wdata;
      presc_d = '0;
      ti_d    = ti_q;
    end
    if (compare_we) begin
      compare_d = wdata;
      ti_d      = 1'b0;
    end
  end

  // Timer state flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_unit.sv
// Purpose: MIPS coprocessor 0 in the MEM stage: exception commit, ERET, mtc0/mfc0, interrupt request, redirect target.
// Latency: register updates visible one cycle after the edge; rdata, int_req and exc_target are combinational.
// Backpressure: none; an exception in the same cycle as mtc0 drops the mtc0.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter int          EXT_INT_W  = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] PRID_VAL   = 32'h004c_0102,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXT_INT_W-1:0] ext_int,
  input  logic                 exc_valid,
  input  logic                 exc_eret,
  input  logic [4:0]           exc_code,
  input  logic [31:0]          exc_pc,
  input  logic                 exc_in_ds,
  input  logic [31:0]          exc_badvaddr,
  input  logic                 exc_bva_we,
  input  logic                 we,
  input  logic [4:0]           waddr,
  input  logic [31:0]          wdata,
  input  logic [4:0]           raddr,
  output logic [31:0]          rdata,
  output logic [31:0]          status_o,
  output logic [31:0]          cause_o,
  output logic [31:0]          epc_o,
  output logic                 int_req,
  output logic [31:0]          exc_target
);

  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        bd_q, bd_d;
  logic [4:0]  excode_q, excode_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [5:0]  ip_hw_q, ip_hw_d;

  logic        exc_take, eret_take, mtc_ok;
  logic [31:0] count, compare;
  logic        ti, ip7;

  assign exc_take  = exc_valid & ~exc_eret;
  assign eret_take = exc_valid & exc_eret;
  // Committing exceptions and ERETs win over any mtc0 in the same cycle
  assign mtc_ok    = we & ~exc_valid;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (mtc_ok && (waddr == CP0_COUNT)),
    .compare_we (mtc_ok && (waddr == CP0_COMPARE)),
    .wdata      (wdata),
    .count_o    (count),
    .compare_o  (compare),
    .ti_o       (ti)
  );

  // Next-state for Status/Cause/EPC/BadVAddr: exception > ERET > mtc0; IP[7:2] samples ext_int every cycle
  always_comb begin
    status_d   = status_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    bd_d       = bd_q;
    excode_d   = excode_q;
    ip_sw_d    = ip_sw_q;
    ip_hw_d    = '0;
    ip_hw_d[EXT_INT_W-1:0] = ext_int;

    if (exc_take) begin
      excode_d         = exc_code;
      status_d[ST_EXL] = 1'b1;
      if (exc_bva_we) badvaddr_d = exc_badvaddr;
      // A nested exception must not overwrite the original return point
      if (!status_q[ST_EXL]) begin
        epc_d = exc_in_ds ? exc_pc - 32'd4 : exc_pc;
        bd_d  = exc_in_ds;
      end
    end else if (eret_take) begin
      status_d[ST_EXL] = 1'b0;
    end else if (mtc_ok) begin
      case (waddr)
        CP0_STATUS: status_d = (status_q & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
        CP0_CAUSE:  ip_sw_d  = wdata[CA_IP_LO +: 2];
        CP0_EPC:    epc_d    = wdata;
        default:    ;
      endcase
    end
  end

  // Architectural register flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q   <= STATUS_RST;
      epc_q      <= '0;
      badvaddr_q <= '0;
      bd_q       <= 1'b0;
      excode_q   <= '0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
    end else begin
      status_q   <= status_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      bd_q       <= bd_d;
      excode_q   <= excode_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ip_hw_d;
    end
  end

  // Timer interrupt shares IP7 with the top hardware line
  assign ip7      = ip_hw_q[5] | ti;
  assign cause_o  = {bd_q, ti, 14'b0, ip7, ip_hw_q[4:0], ip_sw_q, 1'b0, excode_q, 2'b0};
  assign status_o = status_q;
  assign epc_o    = epc_q;

  assign int_req    = status_q[ST_IE] & ~status_q[ST_EXL] &
                      (|(cause_o[CA_IP_LO +: 8] & status_q[ST_IM_LO +: 8]));
  assign exc_target = exc_vector(exc_eret, status_q[ST_BEV], epc_q);

  // mfc0 read mux; forced to zero while reset is held
  always_comb begin
    rdata = '0;
    if (!rst) begin
      case (raddr)
        CP0_BADVADDR: rdata = badvaddr_q;
        CP0_COUNT:    rdata = count;
        CP0_COMPARE:  rdata = compare;
        CP0_STATUS:   rdata = status_q;
        CP0_CAUSE:    rdata = cause_o;
        CP0_EPC:      rdata = epc_q;
        CP0_PRID:     rdata = PRID_VAL;
        CP0_CONFIG:   rdata = CONFIG_VAL;
        default:      rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Purpose: self-checking bench for cp0_unit: register table, timer, interrupts, exceptions, reset.
// Latency: reads are checked one cycle after the write edge that produced them.
// Backpressure: not applicable.
module tb_cp0_unit;
  import cp0_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  ext_int;
  logic        exc_valid, exc_eret, exc_in_ds, exc_bva_we, we;
  logic [4:0]  exc_code, waddr, raddr;
  logic [31:0] exc_pc, exc_badvaddr, wdata, rdata;
  logic [31:0] status_o, cause_o, epc_o, exc_target;
  logic        int_req;

  cp0_unit #(
    .EXT_INT_W (6),
    .COUNT_DIV (2),
    .PRID_VAL  (32'h004c_0102),
    .CONFIG_VAL(32'h0000_8000)
  ) dut (
    .clk(clk), .rst(rst), .ext_int(ext_int),
    .exc_valid(exc_valid), .exc_eret(exc_eret), .exc_code(exc_code),
    .exc_pc(exc_pc), .exc_in_ds(exc_in_ds), .exc_badvaddr(exc_badvaddr),
    .exc_bva_we(exc_bva_we), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .status_o(status_o), .cause_o(cause_o),
    .epc_o(epc_o), .int_req(int_req), .exc_target(exc_target)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0]  raddr;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we         = 1'b0;
    exc_valid  = 1'b0;
    exc_eret   = 1'b0;
    exc_bva_we = 1'b0;
    exc_in_ds  = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    step();
    we    = 1'b0;
  endtask

  task automatic expect_rd(input logic [4:0] a, input logic [31:0] e);
    sb_t s;
    s.raddr = a;
    s.exp   = e;
    sb_q.push_back(s);
  endtask

  // Pop each expected read and compare against the combinational mfc0 port
  task automatic drain();
    sb_t s;
    while (sb_q.size() > 0) begin
      s     = sb_q.pop_front();
      raddr = s.raddr;
      #1;
      check($sformatf("mfc0 r%0d", s.raddr), rdata, s.exp);
    end
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic ds,
                     input logic bva_we, input logic [31:0] bva);
    exc_valid    = 1'b1;
    exc_eret     = 1'b0;
    exc_code     = code;
    exc_pc       = pc;
    exc_in_ds    = ds;
    exc_bva_we   = bva_we;
    exc_badvaddr = bva;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{CP0_STATUS,   32'hFFFF_FFFF, CP0_STATUS,   32'h0040_FF03};
    tbl[1] = '{CP0_STATUS,   32'h0000_0000, CP0_STATUS,   32'h0040_0000};
    tbl[2] = '{CP0_CAUSE,    32'hFFFF_FFFF, CP0_CAUSE,    32'h0000_0300};
    tbl[3] = '{CP0_CAUSE,    32'h0000_0000, CP0_CAUSE,    32'h0000_0000};
    tbl[4] = '{CP0_EPC,      32'hDEAD_BEEF, CP0_EPC,      32'hDEAD_BEEF};
    tbl[5] = '{CP0_COMPARE,  32'h0000_1234, CP0_COMPARE,  32'h0000_1234};
    tbl[6] = '{CP0_PRID,     32'hFFFF_FFFF, CP0_PRID,     32'h004C_0102};
    tbl[7] = '{CP0_CONFIG,   32'h0000_0000, CP0_CONFIG,   32'h0000_8000};
    tbl[8] = '{CP0_BADVADDR, 32'hFFFF_FFFF, CP0_BADVADDR, 32'h0000_0000};
    tbl[9] = '{5'd3,         32'hFFFF_FFFF, 5'd3,         32'h0000_0000};

    rst          = 1'b1;
    ext_int      = '0;
    exc_code     = '0;
    exc_pc       = '0;
    exc_badvaddr = '0;
    waddr        = '0;
    wdata        = '0;
    raddr        = CP0_STATUS;
    idle();

    // Reset state, sampled while reset is held
    #2;
    check("rst rdata",   rdata,    32'h0);
    check("rst status",  status_o, 32'h0040_0000);
    check("rst cause",   cause_o,  32'h0);
    check("rst epc",     epc_o,    32'h0);
    check("rst int_req", {31'b0, int_req}, 32'h0);
    step();
    rst = 1'b0;
    expect_rd(CP0_COUNT,    32'h0);
    expect_rd(CP0_COMPARE,  32'h0);
    expect_rd(CP0_STATUS,   32'h0040_0000);
    expect_rd(CP0_BADVADDR, 32'h0);
    drain();

    // mtc0 masks and read-only registers
    for (int i = 0; i < 10; i++) begin
      mtc0(tbl[i].waddr, tbl[i].wdata);
      expect_rd(tbl[i].raddr, tbl[i].exp);
      drain();
    end

    // Timer: Count reaches Compare=5 ten cycles after Count=0 with a divide-by-2 prescaler
    mtc0(CP0_COMPARE, 32'd5);
    mtc0(CP0_COUNT, 32'd0);
    repeat (9) step();
    check("count before match", {31'b0, cause_o[30]}, 32'h0);
    expect_rd(CP0_COUNT, 32'd4);
    drain();
    step();
    check("TI on match",   {31'b0, cause_o[30]}, 32'h1);
    check("IP7 on match",  {31'b0, cause_o[15]}, 32'h1);
    expect_rd(CP0_COUNT, 32'd5);
    drain();
    mtc0(CP0_COMPARE, 32'hFFFF_FFFF);
    check("TI cleared by compare", {31'b0, cause_o[30]}, 32'h0);
    check("IP7 cleared",           {31'b0, cause_o[15]}, 32'h0);
    // Count written equal to Compare must not raise TI; then it wraps to zero
    mtc0(CP0_COUNT, 32'hFFFF_FFFF);
    check("no TI on count write", {31'b0, cause_o[30]}, 32'h0);
    expect_rd(CP0_COUNT, 32'hFFFF_FFFF);
    drain();
    step();
    step();
    expect_rd(CP0_COUNT, 32'h0);
    drain();
    check("no TI after wrap", {31'b0, cause_o[30]}, 32'h0);

    // Interrupt gating through IE, IM2 and EXL
    mtc0(CP0_STATUS, 32'h0000_0401);
    ext_int = 6'b000001;
    #1;
    check("int_req before sample", {31'b0, int_req}, 32'h0);
    step();
    check("int_req after sample", {31'b0, int_req}, 32'h1);
    mtc0(CP0_STATUS, 32'h0000_0403);
    check("int_req masked by EXL", {31'b0, int_req}, 32'h0);
    ext_int = '0;
    mtc0(CP0_STATUS, 32'h0000_0000);
    check("cause idle", cause_o, 32'h0);

    // Delay-slot exception entry
    exc(EXC_OV, 32'hBFC0_1004, 1'b1, 1'b0, 32'h0);
    #1;
    check("target bev", exc_target, 32'hBFC0_0380);
    step();
    idle();
    check("ds epc",    epc_o,    32'hBFC0_1000);
    check("ds cause",  cause_o,  32'h8000_0030);
    check("ds status", status_o, 32'h0040_0002);

    // Nested exception keeps EPC and BD, updates ExcCode and BadVAddr
    exc(EXC_ADEL, 32'h8000_2000, 1'b0, 1'b1, 32'h8000_2001);
    step();
    idle();
    check("nest epc",   epc_o,   32'hBFC0_1000);
    check("nest cause", cause_o, 32'h8000_0010);
    expect_rd(CP0_BADVADDR, 32'h8000_2001);
    drain();

    // ERET returns to EPC and clears EXL only
    exc_valid = 1'b1;
    exc_eret  = 1'b1;
    exc_code  = 5'd31;
    #1;
    check("eret target", exc_target, 32'hBFC0_1000);
    step();
    idle();
    check("eret status", status_o, 32'h0040_0000);
    check("eret cause",  cause_o,  32'h8000_0010);

    // Exception and mtc0 EPC in the same cycle: the write is lost
    exc(EXC_SYS, 32'h8000_1000, 1'b0, 1'b0, 32'h0);
    we    = 1'b1;
    waddr = CP0_EPC;
    wdata = 32'h0000_1234;
    step();
    idle();
    check("collide epc",   epc_o,   32'h8000_1000);
    check("collide cause", cause_o, 32'h0000_0020);
    exc_valid = 1'b1;
    exc_eret  = 1'b1;
    #1;
    check("collide eret target", exc_target, 32'h8000_1000);
    step();
    idle();
    check("collide eret status", status_o, 32'h0040_0000);

    // Asynchronous reset mid-count with TI pending
    mtc0(CP0_COMPARE, 32'd3);
    mtc0(CP0_COUNT, 32'd0);
    mtc0(CP0_STATUS, 32'h0000_8001);
    repeat (5) step();
    check("pre-reset TI",      {31'b0, cause_o[30]}, 32'h1);
    check("pre-reset int_req", {31'b0, int_req},     32'h1);
    raddr = CP0_COUNT;
    #2;
    rst = 1'b1;
    #1;
    check("arst status",  status_o, 32'h0040_0000);
    check("arst cause",   cause_o,  32'h0);
    check("arst epc",     epc_o,    32'h0);
    check("arst int_req", {31'b0, int_req}, 32'h0);
    check("arst rdata",   rdata,    32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    expect_rd(CP0_COUNT,   32'h0);
    expect_rd(CP0_COMPARE, 32'h0);
    expect_rd(CP0_CAUSE,   32'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
